stump_scan_chain: RTL and testbench
===================================

Name: stump_scan_chain

Overview:
- Parametrised successor to the Stump debugger's read-only register scanner.
- Takes an atomic snapshot of a NUM_REGS x REG_WIDTH register bank plus FLAG_WIDTH flags into a shadow frame.
- Shifts that frame out bit-serially, LSB first, followed by an even-parity bit.
- Optionally shifts a replacement frame in and writes it back to the register bank.

Parameters:
- NUM_REGS, 8, number of registers scanned (>=2).
- REG_WIDTH, 16, bits per register.
- FLAG_WIDTH, 4, width of the flag (cc) input.
- Derived (localparam): SEL_W = $clog2(NUM_REGS).
- Derived (localparam): FRAME_LEN = NUM_REGS*REG_WIDTH + FLAG_WIDTH + 1 (133 at defaults).

Ports:
- scan_clk  in  1  sole clock; all state changes on rising edge.
- scan_rst  in  1  synchronous, active-high reset.
- reg_bank  in  REG_WIDTH  combinational read data of the register selected by reg_sel.
- reg_sel  out  SEL_W  register-bank read/write select.
- cc  in  FLAG_WIDTH  flag register.
- scan_en  in  1  scan-mode enable.
- scan_out  out  1  current frame bit.
- scan_valid  out  1  scan_out carries a frame bit this cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock, scan_clk. Reset is synchronous and active-high on scan_rst, and dominates all other inputs.
- Reset values: state=IDLE, reg_sel=0, scan_out=0, scan_valid=0, busy=0, shadow frame=0, counters=0.
- States: IDLE, CAPTURE, SHIFT (and WRITEBACK when the optional feature is compiled in).
- IDLE:
  - reg_sel=0.
  - scan_en=1 at an edge -> CAPTURE, with idx=0.
- CAPTURE:
  - reg_sel=idx.
  - Each edge loads reg_bank into frame slot idx (bits idx*REG_WIDTH+: REG_WIDTH), then idx++.
  - On the edge where idx==NUM_REGS-1, also load cc into bits NUM_REGS*REG_WIDTH+: FLAG_WIDTH and load the even parity of the whole payload into bit FRAME_LEN-1.
  - Then -> SHIFT with bit_cnt=0.
  - Duration: exactly NUM_REGS cycles.
  - scan_en=0 at any CAPTURE edge -> IDLE (abort); the partial frame is discarded and no valid bits are emitted.
- SHIFT:
  - scan_out=frame[0], scan_valid=1, reg_sel=0.
  - Each edge shifts the frame right by one and increments bit_cnt.
  - Bit order: R0 bit0 ... R(N-1) bit(W-1), cc bit0 ... cc bit(F-1), parity.
  - scan_en=0 at an edge -> IDLE immediately (abort, no error).
  - On the edge where bit_cnt==FRAME_LEN-1:
    - -> CAPTURE if scan_en=1 (continuous re-snapshot; there is no gap other than the NUM_REGS capture cycles);
    - -> IDLE otherwise.
- Latency: first scan_valid cycle begins NUM_REGS edges after the IDLE->CAPTURE edge.
- scan_valid is never high outside SHIFT. scan_out=0 whenever scan_valid=0.
- The snapshot is coherent only if the bank is static across the NUM_REGS capture cycles. The debugger guarantees this by halting the core.
- scan_rst mid-CAPTURE or mid-SHIFT: next cycle is IDLE with all outputs at reset values.

Optional Feature:
- Macro STUMP_SCAN_WRITE_EN.
- When defined, add these ports:
  - scan_in  in  1;
  - reg_wr_en  out  1;
  - reg_wr_data  out  REG_WIDTH;
  - wr_err  out  1, a one-cycle pulse.
- During SHIFT, scan_in enters at frame bit FRAME_LEN-1 on each shift edge. After a full frame, the shadow holds the received frame.
- Completed frame, received parity correct -> WRITEBACK:
  - NUM_REGS cycles; reg_sel=idx, reg_wr_en=1, reg_wr_data=slot idx.
  - scan_en is ignored until complete, then -> IDLE.
  - Received flag bits are not written back.
- Completed frame, parity wrong -> wr_err pulses for one cycle, no writes, -> IDLE.
- Aborted frames never write.
- When the macro is undefined: none of these ports exist, no WRITEBACK state exists, and reg_wr_en is absent.

Decomposition:
- Package stump_scan_pkg:
  - state enum (IDLE, CAPTURE, SHIFT, WRITEBACK);
  - default parameter constants;
  - frame-length function.
- One sub-module, stump_scan_shifter: FRAME_LEN-bit shadow register with parallel slot load, parity generation, serial shift and serial-in. The FSM and counters stay in stump_scan_chain.

Test Plan:
- Reset, then bank R0..R7 = 16'h0001<<i, cc=4'b1010, scan_en held high:
  - scan_valid rises 8 edges after entry;
  - 133 bits observed;
  - bit 0=1, bit 17=1, bits 128..131=0,1,0,1;
  - parity bit=0 (10 ones, even);
  - capture restarts immediately after the frame.
- scan_en dropped during bit 40 of SHIFT -> IDLE on that edge; scan_valid=0 and busy=0 on the next cycle.
- scan_en dropped on CAPTURE cycle 3 -> IDLE; no scan_valid pulse.
- scan_rst asserted mid-SHIFT, together with scan_en=1 -> all outputs 0 on the next cycle; a fresh capture starts only after reset is released.
- Parameter sweep NUM_REGS=4, REG_WIDTH=8, FLAG_WIDTH=2 -> frame length 35; bit order and parity match the reference model.
- With STUMP_SCAN_WRITE_EN:
  - Shift in R3=16'hBEEF with correct parity -> 8 reg_wr_en cycles, reg_sel 0..7, R3 written 16'hBEEF.
  - Same frame with one bit flipped -> wr_err pulse, no writes.

Source files
------------

// File: rtl/stump_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stump_scan_pkg
// Brief    : Shared state encoding, default sizes and frame-length helper for
//            the Stump register scan chain.
// Revision : 1.0 - initial release
// ============================================================================
package stump_scan_pkg;

  localparam int C_NUM_REGS   = 8;
  localparam int C_REG_WIDTH  = 16;
  localparam int C_FLAG_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAPTURE   = 2'd1,
    SHIFT     = 2'd2,
    WRITEBACK = 2'd3
  } scan_state_t;

  // Register payload, flags, then one trailing even-parity bit.
  function automatic int stump_frame_len(input int n_regs, input int reg_w, input int flag_w);
    return n_regs * reg_w + flag_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stump_scan_shifter.sv
`default_nettype none
// ============================================================================
// Module   : stump_scan_shifter
// Brief    : Shadow frame register with per-slot parallel load, parity
//            generation and LSB-first serial shift.
// Options  : STUMP_SCAN_WRITE_EN adds serial-in, slot read-back and received
//            parity check.
// Revision : 1.0 - initial release
// ============================================================================
module stump_scan_shifter
  import stump_scan_pkg::*;
#(
  parameter int NUM_REGS   = C_NUM_REGS,
  parameter int REG_WIDTH  = C_REG_WIDTH,
  parameter int FLAG_WIDTH = C_FLAG_WIDTH
) (
  input  logic                        scan_clk,
  input  logic                        scan_rst,
  input  logic                        load_en,
  input  logic                        load_last,
  input  logic [$clog2(NUM_REGS)-1:0] load_idx,
  input  logic [REG_WIDTH-1:0]        load_data,
  input  logic [FLAG_WIDTH-1:0]       cc,
  input  logic                        shift_en,
  output logic                        ser_out
`ifdef STUMP_SCAN_WRITE_EN
  ,
  input  logic                        ser_in,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output logic [REG_WIDTH-1:0]        rd_data,
  output logic                        rx_par_ok
`endif
);

  localparam int FRAME_LEN = stump_frame_len(NUM_REGS, REG_WIDTH, FLAG_WIDTH);
  localparam int FLAG_LSB  = NUM_REGS * REG_WIDTH;

  logic [FRAME_LEN-1:0] r_frame;
  logic [FRAME_LEN-1:0] w_slot;
  logic [FRAME_LEN-2:0] w_payload;
  logic                 w_parity;
  logic                 w_ser_in;

  always_comb begin
    w_slot = r_frame;
    w_slot[int'(load_idx) * REG_WIDTH +: REG_WIDTH] = load_data;
  end

  // On the final capture edge the flags and parity are taken alongside the last slot.
  assign w_payload = {cc, w_slot[FLAG_LSB-1:0]};
  assign w_parity  = ^w_payload;

`ifdef STUMP_SCAN_WRITE_EN
  assign w_ser_in  = ser_in;
  assign rd_data   = r_frame[int'(rd_idx) * REG_WIDTH +: REG_WIDTH];
  // Parity of the frame as it will stand after the current shift edge.
  assign rx_par_ok = ~(^{ser_in, r_frame[FRAME_LEN-1:1]});
`else
  assign w_ser_in  = 1'b0;
`endif

  always_ff @(posedge scan_clk) begin
    if (scan_rst) begin
      r_frame <= '0;
    end else if (load_en) begin
      if (load_last) begin
        r_frame <= {w_parity, w_payload};
      end else begin
        r_frame <= w_slot;
      end
    end else if (shift_en) begin
      r_frame <= {w_ser_in, r_frame[FRAME_LEN-1:1]};
    end
  end

  assign ser_out = r_frame[0];

endmodule
`default_nettype wire

// File: rtl/stump_scan_chain.sv
`default_nettype none
// ============================================================================
// Module   : stump_scan_chain
// Brief    : Snapshot a register bank plus flags and scan it out bit-serially
//            with trailing even parity; re-snapshots while scan_en stays high.
// Options  : STUMP_SCAN_WRITE_EN adds scan-in and register write-back.
// Revision : 1.0 - initial release
// ============================================================================
module stump_scan_chain
  import stump_scan_pkg::*;
#(
  parameter int NUM_REGS   = C_NUM_REGS,
  parameter int REG_WIDTH  = C_REG_WIDTH,
  parameter int FLAG_WIDTH = C_FLAG_WIDTH
) (
  input  logic                        scan_clk,
  input  logic                        scan_rst,
  input  logic [REG_WIDTH-1:0]        reg_bank,
  output logic [$clog2(NUM_REGS)-1:0] reg_sel,
  input  logic [FLAG_WIDTH-1:0]       cc,
  input  logic                        scan_en,
  output logic                        scan_out,
  output logic                        scan_valid,
  output logic                        busy
`ifdef STUMP_SCAN_WRITE_EN
  ,
  input  logic                        scan_in,
  output logic                        reg_wr_en,
  output logic [REG_WIDTH-1:0]        reg_wr_data,
  output logic                        wr_err
`endif
);

  localparam int SEL_W     = $clog2(NUM_REGS);
  localparam int FRAME_LEN = stump_frame_len(NUM_REGS, REG_WIDTH, FLAG_WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [SEL_W-1:0] C_LAST_IDX = SEL_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(FRAME_LEN - 1);

  scan_state_t      r_state;
  logic [SEL_W-1:0] r_idx;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_busy;
  logic             r_scan_valid;
  logic             w_load_en;
  logic             w_load_last;
  logic             w_shift_en;
  logic             w_ser_out;

`ifdef STUMP_SCAN_WRITE_EN
  logic                 r_wr_err;
  logic                 w_rx_par_ok;
  logic [REG_WIDTH-1:0] w_rd_data;
`endif

  assign w_load_en   = (r_state == CAPTURE);
  assign w_load_last = (r_idx == C_LAST_IDX);
  assign w_shift_en  = (r_state == SHIFT);

  stump_scan_shifter #(
    .NUM_REGS   (NUM_REGS),
    .REG_WIDTH  (REG_WIDTH),
    .FLAG_WIDTH (FLAG_WIDTH)
  ) u_shifter (
    .scan_clk  (scan_clk),
    .scan_rst  (scan_rst),
    .load_en   (w_load_en),
    .load_last (w_load_last),
    .load_idx  (r_idx),
    .load_data (reg_bank),
    .cc        (cc),
    .shift_en  (w_shift_en),
    .ser_out   (w_ser_out)
`ifdef STUMP_SCAN_WRITE_EN
    ,
    .ser_in    (scan_in),
    .rd_idx    (r_idx),
    .rd_data   (w_rd_data),
    .rx_par_ok (w_rx_par_ok)
`endif
  );

  always_ff @(posedge scan_clk) begin
`ifdef STUMP_SCAN_WRITE_EN
    r_wr_err <= 1'b0;
`endif
    if (scan_rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_bit_cnt    <= '0;
      r_busy       <= 1'b0;
      r_scan_valid <= 1'b0;
`ifdef STUMP_SCAN_WRITE_EN
      r_wr_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_idx <= '0;
          if (scan_en) begin
            r_state <= CAPTURE;
            r_busy  <= 1'b1;
          end
        end

        CAPTURE: begin
          if (!scan_en) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end else if (r_idx == C_LAST_IDX) begin
            r_state      <= SHIFT;
            r_idx        <= '0;
            r_bit_cnt    <= '0;
            r_scan_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        SHIFT: begin
          if (!scan_en) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_busy       <= 1'b0;
            r_scan_valid <= 1'b0;
          end else if (r_bit_cnt == C_LAST_BIT) begin
            r_bit_cnt    <= '0;
            r_scan_valid <= 1'b0;
            r_idx        <= '0;
`ifdef STUMP_SCAN_WRITE_EN
            if (w_rx_par_ok) begin
              r_state <= WRITEBACK;
            end else begin
              r_state  <= IDLE;
              r_busy   <= 1'b0;
              r_wr_err <= 1'b1;
            end
`else
            r_state <= CAPTURE;
`endif
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end

`ifdef STUMP_SCAN_WRITE_EN
        // scan_en is deliberately ignored so a good frame is always written in full.
        WRITEBACK: begin
          if (r_idx == C_LAST_IDX) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
`endif

        default: begin
          r_state      <= IDLE;
          r_idx        <= '0;
          r_bit_cnt    <= '0;
          r_busy       <= 1'b0;
          r_scan_valid <= 1'b0;
        end
      endcase
    end
  end

  assign reg_sel    = r_idx;
  assign busy       = r_busy;
  assign scan_valid = r_scan_valid;
  assign scan_out   = r_scan_valid & w_ser_out;

`ifdef STUMP_SCAN_WRITE_EN
  assign reg_wr_en   = (r_state == WRITEBACK);
  assign reg_wr_data = w_rd_data;
  assign wr_err      = r_wr_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stump_scan_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_stump_scan_chain
// Brief    : Scoreboard bench for two stump_scan_chain configurations (8x16x4
//            and 4x8x2) against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stump_scan_chain;

  logic        clk = 1'b0;
  logic        scan_rst = 1'b1;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;

  logic [15:0] bank_a [8];
  logic [7:0]  bank_b [4];
  logic [3:0]  cc_a = '0;
  logic [1:0]  cc_b = '0;

  logic [15:0] reg_bank_a;
  logic [7:0]  reg_bank_b;
  logic [2:0]  reg_sel_a;
  logic [1:0]  reg_sel_b;
  logic        out_a, valid_a, busy_a;
  logic        out_b, valid_b, busy_b;

  int          errors = 0;
  int          checks = 0;
  bit          mon_on = 1'b0;
  bit          q_a[$];
  bit          q_b[$];
  logic        obs_a [256];
  int          pos_a = 0;

  always #5 clk = ~clk;

  assign reg_bank_a = bank_a[reg_sel_a];
  assign reg_bank_b = bank_b[reg_sel_b];

  stump_scan_chain dut_a (
    .scan_clk   (clk),
    .scan_rst   (scan_rst),
    .reg_bank   (reg_bank_a),
    .reg_sel    (reg_sel_a),
    .cc         (cc_a),
    .scan_en    (en_a),
    .scan_out   (out_a),
    .scan_valid (valid_a),
    .busy       (busy_a)
  );

  stump_scan_chain #(
    .NUM_REGS   (4),
    .REG_WIDTH  (8),
    .FLAG_WIDTH (2)
  ) dut_b (
    .scan_clk   (clk),
    .scan_rst   (scan_rst),
    .reg_bank   (reg_bank_b),
    .reg_sel    (reg_sel_b),
    .cc         (cc_b),
    .scan_en    (en_b),
    .scan_out   (out_b),
    .scan_valid (valid_b),
    .busy       (busy_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit valid_of(input int which);
    return (which == 0) ? valid_a : valid_b;
  endfunction

  function automatic bit busy_of(input int which);
    return (which == 0) ? busy_a : busy_b;
  endfunction

  function automatic int qsize(input int which);
    return (which == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic set_en(input int which, input bit v);
    if (which == 0) en_a = v;
    else en_b = v;
  endtask

  task automatic randomize_bank(input int which);
    if (which == 0) begin
      for (int i = 0; i < 8; i++) bank_a[i] = 16'($urandom);
      cc_a = 4'($urandom);
    end else begin
      for (int i = 0; i < 4; i++) bank_b[i] = 8'($urandom);
      cc_b = 2'($urandom);
    end
  endtask

  // Reference frame: registers LSB-first in index order, flags, then even parity.
  task automatic push_frame(input int which, input int nbits);
    bit bits[$];
    bit p = 1'b0;
    if (which == 0) begin
      for (int r = 0; r < 8; r++) for (int b = 0; b < 16; b++) bits.push_back(bank_a[r][b]);
      for (int b = 0; b < 4; b++) bits.push_back(cc_a[b]);
    end else begin
      for (int r = 0; r < 4; r++) for (int b = 0; b < 8; b++) bits.push_back(bank_b[r][b]);
      for (int b = 0; b < 2; b++) bits.push_back(cc_b[b]);
    end
    foreach (bits[i]) p ^= bits[i];
    bits.push_back(p);
    for (int i = 0; i < nbits; i++) begin
      if (which == 0) q_a.push_back(bits[i]);
      else q_b.push_back(bits[i]);
    end
  endtask

  task automatic wait_valid(input int which, output int n);
    n = 0;
    while (!valid_of(which) && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic run_len(input int which, output int n);
    n = 0;
    while (valid_of(which) && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic full_frame(input int which, input bit hold);
    int n;
    int len = (which == 0) ? 133 : 35;
    int nr  = (which == 0) ? 8 : 4;
    randomize_bank(which);
    push_frame(which, len);
    set_en(which, 1'b1);
    tick();
    chk("entry_busy", int'(busy_of(which)), 1);
    wait_valid(which, n);
    chk("latency", n, nr);
    if (hold) begin
      run_len(which, n);
      chk("frame_len", n, len);
      chk("recapture_busy", int'(busy_of(which)), 1);
      chk("recapture_valid", int'(valid_of(which)), 0);
    end else begin
      repeat (len - 1) tick();
      chk("last_bit_valid", int'(valid_of(which)), 1);
    end
    set_en(which, 1'b0);
    tick();
    chk("end_valid", int'(valid_of(which)), 0);
    chk("end_busy", int'(busy_of(which)), 0);
    chk("queue_drained", qsize(which), 0);
  endtask

  always @(negedge clk) begin : mon_a
    bit e;
    if (mon_on) begin
      if (valid_a) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_valid", 1, 0);
        end else begin
          e = q_a.pop_front();
          chk("a_bit", int'(out_a), int'(e));
        end
        if (pos_a < 256) obs_a[pos_a] = out_a;
        pos_a++;
      end else begin
        pos_a = 0;
        chk("a_idle_out", int'(out_a), 0);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    bit e;
    if (mon_on) begin
      if (valid_b) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_valid", 1, 0);
        end else begin
          e = q_b.pop_front();
          chk("b_bit", int'(out_b), int'(e));
        end
      end else begin
        chk("b_idle_out", int'(out_b), 0);
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 8; i++) bank_a[i] = '0;
    for (int i = 0; i < 4; i++) bank_b[i] = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_valid_a", int'(valid_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_out_a", int'(out_a), 0);
    chk("rst_sel_a", int'(reg_sel_a), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    scan_rst = 1'b0;
    mon_on = 1'b1;
    tick();
    chk("idle_busy_a", int'(busy_a), 0);

    // Directed frame, held scan_en: full frame, immediate re-capture, abort at bit 40
    for (int i = 0; i < 8; i++) bank_a[i] = 16'h0001 << i;
    cc_a = 4'b1010;
    push_frame(0, 133);
    push_frame(0, 41);
    en_a = 1'b1;
    tick();
    chk("dir_entry_busy", int'(busy_a), 1);
    wait_valid(0, n);
    chk("dir_latency", n, 8);
    run_len(0, n);
    chk("dir_frame_len", n, 133);
    chk("dir_bit0", int'(obs_a[0]), 1);
    chk("dir_bit17", int'(obs_a[17]), 1);
    chk("dir_bit128", int'(obs_a[128]), 0);
    chk("dir_bit129", int'(obs_a[129]), 1);
    chk("dir_bit130", int'(obs_a[130]), 0);
    chk("dir_bit131", int'(obs_a[131]), 1);
    chk("dir_parity", int'(obs_a[132]), 0);
    chk("dir_recapture_busy", int'(busy_a), 1);
    wait_valid(0, n);
    chk("dir_recapture_latency", n, 8);
    repeat (40) tick();
    en_a = 1'b0;
    tick();
    chk("abort_shift_valid", int'(valid_a), 0);
    chk("abort_shift_busy", int'(busy_a), 0);
    chk("abort_shift_queue", q_a.size(), 0);

    // Abort on the third capture cycle: no bits may appear
    randomize_bank(0);
    en_a = 1'b1;
    repeat (3) tick();
    en_a = 1'b0;
    tick();
    chk("abort_cap_busy", int'(busy_a), 0);
    repeat (12) tick();
    chk("abort_cap_valid", int'(valid_a), 0);

    // Reset mid-shift with scan_en still high
    randomize_bank(0);
    push_frame(0, 11);
    en_a = 1'b1;
    tick();
    wait_valid(0, n);
    chk("rst_mid_latency", n, 8);
    repeat (10) tick();
    scan_rst = 1'b1;
    tick();
    chk("rst_mid_valid", int'(valid_a), 0);
    chk("rst_mid_busy", int'(busy_a), 0);
    chk("rst_mid_out", int'(out_a), 0);
    chk("rst_mid_sel", int'(reg_sel_a), 0);
    tick();
    chk("rst_hold_busy", int'(busy_a), 0);
    chk("rst_mid_queue", q_a.size(), 0);
    scan_rst = 1'b0;
    push_frame(0, 133);
    tick();
    chk("post_rst_busy", int'(busy_a), 1);
    wait_valid(0, n);
    chk("post_rst_latency", n, 8);
    repeat (132) tick();
    en_a = 1'b0;
    tick();
    chk("post_rst_idle", int'(busy_a), 0);
    chk("post_rst_queue", q_a.size(), 0);

    // Random frames on both configurations
    for (int k = 0; k < 3; k++) full_frame(0, 1'b0);
    full_frame(0, 1'b1);
    for (int k = 0; k < 3; k++) full_frame(1, 1'b1);
    for (int k = 0; k < 3; k++) full_frame(1, 1'b0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
